cpu86_mem_master: RTL and testbench

CPU86_MEM_MASTER -- requirements
Module: cpu86_mem_master

---
 rtl/cpu86_mem_master_if.sv | 29 ++
 rtl/cpu86_mem_master.sv | 138 +++++++++++++
 tb/tb_cpu86_mem_master.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu86_mem_master_if.sv
// Bus bundle between the CPU-side access port, the 32-bit memory port and the read-return port.
// The master modport is the bridge; the slave modport is the environment around it.
interface cpu86_mem_master_if;
  logic        s_axis_cmd_tvalid;
  logic        s_axis_cmd_tready;
  logic [37:0] s_axis_cmd_tdata;
  logic        m_axis_req_tvalid;
  logic        m_axis_req_tready;
  logic [63:0] m_axis_req_tdata;
  logic        s_axis_res_tvalid;
  logic [31:0] s_axis_res_tdata;
  logic        m_axis_rd_tvalid;
  logic [15:0] m_axis_rd_tdata;
  logic        err;

  modport master (
    input  s_axis_cmd_tvalid, s_axis_cmd_tdata, m_axis_req_tready,
           s_axis_res_tvalid, s_axis_res_tdata,
    output s_axis_cmd_tready, m_axis_req_tvalid, m_axis_req_tdata,
           m_axis_rd_tvalid, m_axis_rd_tdata, err
  );

  modport slave (
    output s_axis_cmd_tvalid, s_axis_cmd_tdata, m_axis_req_tready,
           s_axis_res_tvalid, s_axis_res_tdata,
    input  s_axis_cmd_tready, m_axis_req_tvalid, m_axis_req_tdata,
           m_axis_rd_tvalid, m_axis_rd_tdata, err
  );
endinterface

// File: rtl/cpu86_mem_master.sv
// Bridges 8/16-bit CPU accesses on a 20-bit byte address space onto a 32-bit word memory,
// splitting a 16-bit access at lane 3 into two word requests and reassembling read data.
module cpu86_mem_master (
  input  logic                  clk,
  input  logic                  resetn,
  cpu86_mem_master_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2, WAIT} state_t;

  state_t      state_q, state_d;
  logic        req_valid_q;
  logic [63:0] req_data_q, req2_q;
  logic        split_q, read_q, wide_q, rcv_q;
  logic [1:0]  lane_q, pend_q;
  logic [7:0]  first_byte_q;
  logic        rd_valid_q, err_q;
  logic [15:0] rd_data_q, rd_data_d;

  logic [15:0] cmd_wdata;
  logic [19:0] cmd_addr;
  logic [17:0] cmd_word;
  logic [1:0]  cmd_lane;
  logic        cmd_we, cmd_wide, cmd_split;
  logic [3:0]  mask1;
  logic [31:0] data1, data2, res_shift;
  logic        cmd_fire, req_fire, res_ok, res_bad, last_res;

  function automatic logic [63:0] pack_req(logic [3:0] mask, logic we,
                                           logic [17:0] word, logic [31:0] data);
    return {2'b00, mask, we, 7'b0, word, data};
  endfunction

  assign cmd_wdata = bus.s_axis_cmd_tdata[15:0];
  assign cmd_addr  = bus.s_axis_cmd_tdata[35:16];
  assign cmd_we    = bus.s_axis_cmd_tdata[36];
  assign cmd_wide  = bus.s_axis_cmd_tdata[37];
  assign cmd_word  = cmd_addr[19:2];
  assign cmd_lane  = cmd_addr[1:0];
  assign cmd_split = cmd_wide & (cmd_lane == 2'd3);

  // Ready is gated by resetn so the port reads 0 while reset is held.
  assign bus.s_axis_cmd_tready = resetn & (state_q == IDLE);

  assign cmd_fire = bus.s_axis_cmd_tvalid & bus.s_axis_cmd_tready;
  assign req_fire = req_valid_q & bus.m_axis_req_tready;
  assign res_ok   = bus.s_axis_res_tvalid & (pend_q != 2'd0);
  assign res_bad  = bus.s_axis_res_tvalid & (pend_q == 2'd0);
  assign last_res = res_ok & (~split_q | rcv_q);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    mask1 = 4'b0001 << cmd_lane;
    data1 = {4{cmd_wdata[7:0]}};
    data2 = {24'h0, cmd_wdata[15:8]};
    if (cmd_wide) begin
      if (cmd_split) begin
        mask1 = 4'b1000;
        data1 = {cmd_wdata[7:0], 24'h0};
      end else begin
        mask1 = 4'b0011 << cmd_lane;
        data1 = {16'h0, cmd_wdata} << {cmd_lane, 3'b000};
      end
    end
  end

  always_comb begin
    res_shift = bus.s_axis_res_tdata >> {lane_q, 3'b000};
    rd_data_d = {8'h00, res_shift[7:0]};
    if (split_q)     rd_data_d = {bus.s_axis_res_tdata[7:0], first_byte_q};
    else if (wide_q) rd_data_d = res_shift[15:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cmd_fire) state_d = ISSUE1;
      ISSUE1: if (req_fire) state_d = split_q ? ISSUE2 : (read_q ? WAIT : IDLE);
      ISSUE2: if (req_fire) state_d = read_q ? WAIT : IDLE;
      WAIT:   if (last_res) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_valid_q  <= 1'b0;
      req_data_q   <= '0;
      req2_q       <= '0;
      split_q      <= 1'b0;
      read_q       <= 1'b0;
      wide_q       <= 1'b0;
      lane_q       <= '0;
      rcv_q        <= 1'b0;
      pend_q       <= '0;
      first_byte_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      rd_valid_q <= last_res;
      pend_q     <= pend_q + {1'b0, req_fire & read_q} - {1'b0, res_ok};
      if (cmd_fire) begin
        req_valid_q <= 1'b1;
        req_data_q  <= pack_req(mask1, cmd_we, cmd_word, data1);
        req2_q      <= pack_req(4'b0001, cmd_we, cmd_word + 18'd1, data2);
        split_q     <= cmd_split;
        read_q      <= ~cmd_we;
        wide_q      <= cmd_wide;
        lane_q      <= cmd_lane;
        rcv_q       <= 1'b0;
      end else if (req_fire) begin
        if (state_q == ISSUE1 && split_q) req_data_q  <= req2_q;
        else                              req_valid_q <= 1'b0;
      end
      // The first response of a split read may land while the second request is still stalled.
      if (res_ok) begin
        rcv_q <= 1'b1;
        if (!rcv_q) first_byte_q <= bus.s_axis_res_tdata[31:24];
      end
      if (last_res) rd_data_q <= rd_data_d;
      if (res_bad)  err_q     <= 1'b1;
    end
  end

  assign bus.m_axis_req_tvalid = req_valid_q;
  assign bus.m_axis_req_tdata  = req_data_q;
  assign bus.m_axis_rd_tvalid  = rd_valid_q;
  assign bus.m_axis_rd_tdata   = rd_data_q;
  assign bus.err               = err_q;

endmodule

// File: tb/tb_cpu86_mem_master.sv
// Directed bench for cpu86_mem_master: writes, reads, split accesses, wrap, stall and error/reset.
module tb_cpu86_mem_master;

  logic clk;
  logic resetn;
  int   total;
  int   passed;

  cpu86_mem_master_if bus ();

  cpu86_mem_master dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [37:0] mk_cmd(logic wide, logic we, logic [19:0] a, logic [15:0] wd);
    return {wide, we, a, wd};
  endfunction

  function automatic logic [63:0] mk_req(logic [3:0] m, logic c, logic [17:0] a, logic [31:0] d);
    return {2'b00, m, c, 7'b0, a, d};
  endfunction

  // Presents one command; returns in the cycle after acceptance.
  task automatic send(input logic [37:0] cmd);
    bus.s_axis_cmd_tvalid = 1'b1;
    bus.s_axis_cmd_tdata  = cmd;
    tick();
    bus.s_axis_cmd_tvalid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] word);
    bus.s_axis_res_tvalid = 1'b1;
    bus.s_axis_res_tdata  = word;
    tick();
    bus.s_axis_res_tvalid = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    resetn = 1'b0;
    bus.s_axis_cmd_tvalid = 1'b0;
    bus.s_axis_cmd_tdata  = '0;
    bus.m_axis_req_tready = 1'b1;
    bus.s_axis_res_tvalid = 1'b0;
    bus.s_axis_res_tdata  = '0;

    // Reset state
    repeat (2) tick();
    check("rst_cmd_ready", bus.s_axis_cmd_tready, 0);
    check("rst_req_valid", bus.m_axis_req_tvalid, 0);
    check("rst_rd_valid",  bus.m_axis_rd_tvalid, 0);
    check("rst_err",       bus.err, 0);
    check("rst_req_data",  bus.m_axis_req_tdata, 0);
    check("rst_rd_data",   bus.m_axis_rd_tdata, 0);
    resetn = 1'b1;
    tick();
    check("idle_ready", bus.s_axis_cmd_tready, 1);

    // Byte write A=0x00005, wdata 0xAB
    send(mk_cmd(1'b0, 1'b1, 20'h00005, 16'h00AB));
    check("bw_req_valid", bus.m_axis_req_tvalid, 1);
    check("bw_req_data",  bus.m_axis_req_tdata, mk_req(4'b0010, 1'b1, 18'd1, 32'hABABABAB));
    check("bw_busy",      bus.s_axis_cmd_tready, 0);
    tick();
    check("bw_req_done",  bus.m_axis_req_tvalid, 0);
    check("bw_idle",      bus.s_axis_cmd_tready, 1);
    check("bw_no_rd",     bus.m_axis_rd_tvalid, 0);

    // Word read A=0x00002 against a 2-cycle responder: accept c0, req c1, res c3, rd c4
    send(mk_cmd(1'b1, 1'b0, 20'h00002, 16'h0000));
    check("wr_req_valid", bus.m_axis_req_tvalid, 1);
    check("wr_req_addr",  bus.m_axis_req_tdata[56:32], 0);
    check("wr_req_mask",  bus.m_axis_req_tdata[61:58], 4'b1100);
    check("wr_req_cmd",   bus.m_axis_req_tdata[57], 0);
    tick();
    check("wr_req_done",  bus.m_axis_req_tvalid, 0);
    check("wr_wait_busy", bus.s_axis_cmd_tready, 0);
    tick();
    check("wr_rd_early",  bus.m_axis_rd_tvalid, 0);
    respond(32'h12345678);
    check("wr_rd_valid",  bus.m_axis_rd_tvalid, 1);
    check("wr_rd_data",   bus.m_axis_rd_tdata, 16'h1234);
    check("wr_idle",      bus.s_axis_cmd_tready, 1);
    tick();
    check("wr_rd_pulse",  bus.m_axis_rd_tvalid, 0);

    // Byte read lane 2: A=0x00006, word 0x11223344 -> 0x0022
    send(mk_cmd(1'b0, 1'b0, 20'h00006, 16'h0000));
    check("br_req_mask",  bus.m_axis_req_tdata[61:58], 4'b0100);
    check("br_req_addr",  bus.m_axis_req_tdata[56:32], 1);
    tick();
    respond(32'h11223344);
    check("br_rd_valid",  bus.m_axis_rd_tvalid, 1);
    check("br_rd_data",   bus.m_axis_rd_tdata, 16'h0022);

    // Split write A=0x00007, wdata 0xBEEF
    send(mk_cmd(1'b1, 1'b1, 20'h00007, 16'hBEEF));
    check("sw_req1", bus.m_axis_req_tdata, mk_req(4'b1000, 1'b1, 18'd1, 32'hEF000000));
    tick();
    check("sw_req2_valid", bus.m_axis_req_tvalid, 1);
    check("sw_req2", bus.m_axis_req_tdata, mk_req(4'b0001, 1'b1, 18'd2, 32'h000000BE));
    tick();
    check("sw_done",  bus.m_axis_req_tvalid, 0);
    check("sw_idle",  bus.s_axis_cmd_tready, 1);
    check("sw_no_rd", bus.m_axis_rd_tvalid, 0);

    // Split read with wrap: A=0xFFFFF, word 0x3FFFF=0xAA000000, word 0=0x000000CC
    send(mk_cmd(1'b1, 1'b0, 20'hFFFFF, 16'h0000));
    check("sr_req1_addr", bus.m_axis_req_tdata[56:32], 25'h003FFFF);
    check("sr_req1_mask", bus.m_axis_req_tdata[61:58], 4'b1000);
    tick();
    check("sr_req2_addr", bus.m_axis_req_tdata[56:32], 0);
    check("sr_req2_mask", bus.m_axis_req_tdata[61:58], 4'b0001);
    tick();
    respond(32'hAA000000);
    check("sr_rd_early", bus.m_axis_rd_tvalid, 0);
    respond(32'h000000CC);
    check("sr_rd_valid", bus.m_axis_rd_tvalid, 1);
    check("sr_rd_data",  bus.m_axis_rd_tdata, 16'hCCAA);

    // Split read A=0x00003 with the second request stalled 5 cycles; first response arrives meanwhile
    send(mk_cmd(1'b1, 1'b0, 20'h00003, 16'h0000));
    check("st_req1_mask", bus.m_axis_req_tdata[61:58], 4'b1000);
    tick();
    bus.m_axis_req_tready = 1'b0;
    bus.s_axis_res_tdata  = 32'h5A000000;
    for (int i = 0; i < 5; i++) begin
      bus.s_axis_res_tvalid = (i == 1);
      check("st_valid", bus.m_axis_req_tvalid, 1);
      check("st_hold",  bus.m_axis_req_tdata[63:32], 32'h04000001);
      check("st_no_rd", bus.m_axis_rd_tvalid, 0);
      tick();
    end
    bus.s_axis_res_tvalid = 1'b0;
    bus.m_axis_req_tready = 1'b1;
    check("st_hold_last", bus.m_axis_req_tdata[63:32], 32'h04000001);
    tick();
    check("st_req_done", bus.m_axis_req_tvalid, 0);
    check("st_rd_early", bus.m_axis_rd_tvalid, 0);
    respond(32'h00000077);
    check("st_rd_valid", bus.m_axis_rd_tvalid, 1);
    check("st_rd_data",  bus.m_axis_rd_tdata, 16'h775A);
    tick();
    check("st_rd_pulse", bus.m_axis_rd_tvalid, 0);
    check("st_no_err",   bus.err, 0);

    // Unexpected response in IDLE sets a sticky error
    respond(32'hDEADBEEF);
    check("err_set",    bus.err, 1);
    check("err_no_rd",  bus.m_axis_rd_tvalid, 0);
    repeat (3) tick();
    check("err_sticky", bus.err, 1);

    // Reset asserted while a read waits for its response
    send(mk_cmd(1'b0, 1'b0, 20'h00010, 16'h0000));
    tick();
    resetn = 1'b0;
    #1;
    check("ab_cmd_ready", bus.s_axis_cmd_tready, 0);
    check("ab_req_valid", bus.m_axis_req_tvalid, 0);
    check("ab_rd_valid",  bus.m_axis_rd_tvalid, 0);
    check("ab_err",       bus.err, 0);
    check("ab_req_data",  bus.m_axis_req_tdata, 0);
    check("ab_rd_data",   bus.m_axis_rd_tdata, 0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("ab_idle",      bus.s_axis_cmd_tready, 1);
    check("ab_no_req",    bus.m_axis_req_tvalid, 0);
    respond(32'h000000FF);
    check("ab_late_err",  bus.err, 1);
    check("ab_late_rd",   bus.m_axis_rd_tvalid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
